// File: rtl/function_evaluation_core.sv
`default_nettype none
// ============================================================================
// Module   : function_evaluation_core
// Purpose  : Single-precision multiply-accumulate (CLEAR / GO / READ) behind a
//            start/done custom-instruction port. Optional rounding macro:
//            FUNCTION_EVALUATION_ROUND_EN (round to nearest even; else truncate).
// Revision : 1.0 - initial release
// ============================================================================
module function_evaluation_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] x_one,
    input  logic [31:0] x_two,
    output logic [31:0] result,
    output logic        done
);
`ifdef FUNCTION_EVALUATION_ROUND_EN
    localparam int c_GRD = 3;
`else
    localparam int c_GRD = 0;
`endif
    localparam int c_MW = 24 + c_GRD;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_MUL0 = 3'd1, S_MUL1 = 3'd2, S_ADD0 = 3'd3,
        S_ADD1 = 3'd4, S_ADD2 = 3'd5, S_DONE = 3'd6
    } state_t;

    state_t             r_state;
    logic [31:0]        r_a, r_b, r_acc, r_p;
    logic [47:0]        r_prod;
    logic               r_psign, r_pzero, r_asign, r_asub;
    logic signed [9:0]  r_pexp;
    logic [7:0]         r_aexp;
    logic [c_MW-1:0]    r_big, r_small;
    logic [c_MW:0]      r_sum;

    logic [c_MW-1:0]    w_pm, w_bman, w_sman, w_shifted, w_nm;
    logic [31:0]        w_p, w_bg, w_sm, w_sum_out;
    logic [7:0]         w_diff;
    logic [4:0]         w_lz;
    logic signed [9:0]  w_ne;
    logic               w_acc_big;

    // Flush exponent underflow to signed zero, saturate overflow to infinity.
    function automatic logic [31:0] f_pack(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] m);
        if (e <= 0)
            f_pack = {s, 31'd0};
        else if (e >= 255)
            f_pack = {s, 8'hFF, 23'd0};
        else
            f_pack = {s, e[7:0], m};
    endfunction

`ifdef FUNCTION_EVALUATION_ROUND_EN
    logic [32:0] w_pr, w_sr;

    // m = {hidden, 23 fraction, guard, round, sticky}; returns {exponent, fraction}.
    function automatic logic [32:0] f_round(input logic [26:0] m, input logic signed [9:0] e);
        logic [24:0] r;
        r = {1'b0, m[26:3]} + 25'(m[2] & (m[3] | m[1] | m[0]));
        if (r[24])
            f_round = {e + 10'sd1, r[23:1]};
        else
            f_round = {e, r[22:0]};
    endfunction
`else
    logic w_unused;
    assign w_unused = ^{r_prod[22:0], w_pm[c_MW-1], w_nm[c_MW-1]};
`endif

    // Product normalise (0 or 1 bit) and pack.
    always_comb begin
`ifdef FUNCTION_EVALUATION_ROUND_EN
        w_pm = r_prod[47] ? {r_prod[47:22], |r_prod[21:0]} : {r_prod[46:21], |r_prod[20:0]};
        w_pr = f_round(w_pm, r_pexp + $signed({9'd0, r_prod[47]}));
        w_p  = r_pzero ? {r_psign, 31'd0} : f_pack(r_psign, w_pr[32:23], w_pr[22:0]);
`else
        w_pm = r_prod[47] ? r_prod[47:24] : r_prod[46:23];
        w_p  = r_pzero ? {r_psign, 31'd0}
                       : f_pack(r_psign, r_pexp + $signed({9'd0, r_prod[47]}), w_pm[22:0]);
`endif
    end

    // Alignment: larger magnitude becomes the reference operand.
    always_comb begin
        w_acc_big = r_acc[30:0] >= r_p[30:0];
        w_bg      = w_acc_big ? r_acc : r_p;
        w_sm      = w_acc_big ? r_p : r_acc;
        w_diff    = w_bg[30:23] - w_sm[30:23];
        w_bman    = (w_bg[30:23] == 8'd0) ? '0 : (c_MW'({1'b1, w_bg[22:0]}) << c_GRD);
        w_sman    = (w_sm[30:23] == 8'd0) ? '0 : (c_MW'({1'b1, w_sm[22:0]}) << c_GRD);
        w_shifted = (w_diff >= 8'd25) ? '0 : (w_sman >> w_diff);
`ifdef FUNCTION_EVALUATION_ROUND_EN
        if (w_diff < 8'd25 && |(w_sman & ~({c_MW{1'b1}} << w_diff)))
            w_shifted[0] = 1'b1;
`endif
    end

    // Sum normalise: carry-out right shift or leading-zero left shift.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < c_MW; i++)
            if (r_sum[i])
                w_lz = 5'(c_MW - 1 - i);
        if (r_sum[c_MW]) begin
            w_nm = r_sum[c_MW:1];
`ifdef FUNCTION_EVALUATION_ROUND_EN
            w_nm[0] = r_sum[1] | r_sum[0];
`endif
            w_ne = $signed({2'b00, r_aexp}) + 10'sd1;
        end else begin
            w_nm = r_sum[c_MW-1:0] << w_lz;
            w_ne = $signed({2'b00, r_aexp}) - $signed({5'd0, w_lz});
        end
`ifdef FUNCTION_EVALUATION_ROUND_EN
        w_sr      = f_round(w_nm, w_ne);
        w_sum_out = (r_sum == '0) ? 32'd0 : f_pack(r_asign, w_sr[32:23], w_sr[22:0]);
`else
        w_sum_out = (r_sum == '0) ? 32'd0 : f_pack(r_asign, w_ne, w_nm[22:0]);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            result  <= '0;
            done    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_p     <= '0;
            r_prod  <= '0;
            r_psign <= 1'b0;
            r_pzero <= 1'b0;
            r_pexp  <= '0;
            r_asign <= 1'b0;
            r_asub  <= 1'b0;
            r_aexp  <= '0;
            r_big   <= '0;
            r_small <= '0;
            r_sum   <= '0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a <= x_one;
                        r_b <= x_two;
                        if (n == 2'd0)
                            r_acc <= '0;
                        r_state <= (n == 2'd1) ? S_MUL0 : S_DONE;
                    end
                end
                S_MUL0: begin
                    r_psign <= r_a[31] ^ r_b[31];
                    r_pexp  <= $signed({2'b00, r_a[30:23]}) + $signed({2'b00, r_b[30:23]}) - 10'sd127;
                    r_pzero <= (r_a[30:23] == 8'd0) || (r_b[30:23] == 8'd0);
                    r_prod  <= 48'({1'b1, r_a[22:0]}) * 48'({1'b1, r_b[22:0]});
                    r_state <= S_MUL1;
                end
                S_MUL1: begin
                    r_p     <= w_p;
                    r_state <= S_ADD0;
                end
                S_ADD0: begin
                    r_big   <= w_bman;
                    r_small <= w_shifted;
                    r_aexp  <= w_bg[30:23];
                    r_asign <= w_bg[31];
                    r_asub  <= w_bg[31] ^ w_sm[31];
                    r_state <= S_ADD1;
                end
                S_ADD1: begin
                    r_sum   <= r_asub ? ({1'b0, r_big} - {1'b0, r_small})
                                      : ({1'b0, r_big} + {1'b0, r_small});
                    r_state <= S_ADD2;
                end
                S_ADD2: begin
                    r_acc   <= w_sum_out;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    result  <= r_acc;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_function_evaluation_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_function_evaluation_core
// Purpose  : Directed self-checking bench for function_evaluation_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_function_evaluation_core;
    localparam logic [1:0] c_CLR = 2'd0;
    localparam logic [1:0] c_GO  = 2'd1;
    localparam logic [1:0] c_RD  = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  n = 2'd0;
    logic [31:0] x_one = '0;
    logic [31:0] x_two = '0;
    logic [31:0] result;
    logic        done;

    int total = 0;
    int bad   = 0;

    function_evaluation_core dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .x_one  (x_one),
        .x_two  (x_two),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble operands to prove capture.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        n     = op;
        x_one = a;
        x_two = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        x_one = 32'hDEADBEEF;
        x_two = 32'h12345678;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [31:0] exp);
        int cnt = 0;
        while (cnt < 30) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done) break;
        end
        check({tag, "_lat"}, 32'(cnt), 32'(lat));
        check({tag, "_res"}, result, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        int lat;
        logic [31:0] res;

        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        issue(c_CLR, 32'h0, 32'h0);
        wait_done("clear0", 1, 32'h0);
        issue(c_GO, 32'h40A00000, 32'h40C00000);
        wait_done("go_5x6", 6, 32'h41F00000);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        issue(c_GO, 32'h40A00000, 32'h40200000);
        wait_done("go_5x2p5", 6, 32'h422A0000);
        issue(c_RD, 32'h43340000, 32'hC2700000);
        wait_done("read2", 1, 32'h422A0000);
        issue(2'd3, 32'h43340000, 32'hC2700000);
        wait_done("read3", 1, 32'h422A0000);
        issue(c_CLR, 32'h43340000, 32'hC2700000);
        wait_done("clear", 1, 32'h0);
        issue(c_RD, 32'h0, 32'h0);
        wait_done("read_zero", 1, 32'h0);

        // GO with a stray CLEAR request two cycles in.
        issue(c_GO, 32'h43340000, 32'hC2700000);
        ndone = 0;
        lat   = 0;
        res   = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin start = 1'b1; n = c_CLR; end
            if (i == 2) start = 1'b0;
            if (done) begin ndone++; lat = i; res = result; end
        end
        check("ignored_start_ndone", 32'(ndone), 32'd1);
        check("ignored_start_lat", 32'(lat), 32'd6);
        check("go_180xm60_res", res, 32'hC628C000);

        // -10800 + 100*100 = -800, with four disabled edges mid-flight.
        issue(c_GO, 32'h42C80000, 32'h42C80000);
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2) clk_en = 1'b0;
            if (lat == 6) clk_en = 1'b1;
            if (done) break;
        end
        check("clken_lat", 32'(lat), 32'd10);
        check("clken_res", result, 32'hC4480000);
        clk_en = 1'b0;
        @(posedge clk);
        #1;
        check("done_frozen", 32'(done), 32'd1);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("done_released", 32'(done), 32'd0);

        // Exact cancellation gives +0.
        issue(c_CLR, 32'h0, 32'h0);
        wait_done("clear_c", 1, 32'h0);
        issue(c_GO, 32'h40A00000, 32'h40C00000);
        wait_done("go_30", 6, 32'h41F00000);
        issue(c_GO, 32'h40A00000, 32'hC0C00000);
        wait_done("cancel", 6, 32'h00000000);

        // Exponent overflow saturates to +inf.
        issue(c_GO, 32'h7F000000, 32'h40000000);
        wait_done("overflow", 6, 32'h7F800000);

        // Reset mid-GO discards the operation.
        issue(c_GO, 32'h40A00000, 32'h40C00000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_result", result, 32'h0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        issue(c_RD, 32'h0, 32'h0);
        wait_done("read_after_rst", 1, 32'h0);

        // Denormal operand and underflowing product both flush to zero.
        issue(c_GO, 32'h00400000, 32'h7F000000);
        wait_done("denorm_in", 6, 32'h0);
        issue(c_GO, 32'h00800000, 32'h3E800000);
        wait_done("underflow", 6, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
